// File: rtl/mcu51_pkg.sv
// Shared 8051 core definitions: sequencer state encoding, reset PC, opcode names, instruction length map.
// Combinational helpers only; FETCH_STEP_EN adds the STEP_WAIT state.
package mcu51_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_EXEC = 3'd3
`ifdef FETCH_STEP_EN
    , STEP_WAIT = 3'd4
`endif
  } seq_state_t;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  localparam logic [7:0] OP_NOP          = 8'h00;
  localparam logic [7:0] OP_INC_A        = 8'h04;
  localparam logic [7:0] OP_DEC_A        = 8'h14;
  localparam logic [7:0] OP_LJMP         = 8'h02;
  localparam logic [7:0] OP_AJMP         = 8'h01;
  localparam logic [7:0] OP_SJMP         = 8'h80;
  localparam logic [7:0] OP_MOV_A_IMM    = 8'h74;
  localparam logic [7:0] OP_MOV_DPTR_IMM = 8'h90;

  // Standard 8051 opcode map, decoded by low nibble (column) then high nibble (row).
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [1:0] len;
    hi  = op[7:4];
    lo  = op[3:0];
    len = 2'd1;
    if (lo == 4'h1) begin
      len = 2'd2;
    end else if (lo >= 4'h6) begin
      // @Ri and Rn columns share a layout; DJNZ Rn,rel exists only for Rn
      if (hi == 4'h7 || hi == 4'h8 || hi == 4'hA) len = 2'd2;
      else if (hi == 4'hB) len = 2'd3;
      else if (hi == 4'hD && lo >= 4'h8) len = 2'd2;
    end else begin
      case (lo)
        4'h0: begin
          if (hi inside {4'h1, 4'h2, 4'h3, 4'h9}) len = 2'd3;
          else if (hi inside {[4'h4:4'h8], [4'hA:4'hD]}) len = 2'd2;
        end
        4'h2: begin
          if (hi <= 4'h1) len = 2'd3;
          else if (hi >= 4'h4 && hi <= 4'hD) len = 2'd2;
        end
        4'h3: if (hi inside {4'h4, 4'h5, 4'h6}) len = 2'd3;
        4'h4: begin
          if (hi inside {[4'h2:4'h7], 4'h9}) len = 2'd2;
          else if (hi == 4'hB) len = 2'd3;
        end
        4'h5: begin
          if (hi inside {4'h7, 4'h8, 4'hB, 4'hD}) len = 2'd3;
          else if (hi != 4'hA) len = 2'd2;
        end
        default: len = 2'd1;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/ins_len_lut.sv
// Opcode byte to instruction length (1..3) lookup.
// Purely combinational, zero latency, no flow control.
module ins_len_lut
  import mcu51_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  assign len = op_len(opcode);

endmodule

// File: rtl/fetch_sequencer.sv
// 8051 fetch/issue sequencer: N fetch cycles (+1 per ROM wait) then a 1-cycle ins_valid; holds until exec_done.
// ROM stalls via rom_ack with rom_req held; optional single-step gate under FETCH_STEP_EN.
module fetch_sequencer
  import mcu51_pkg::*;
#(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ack,
  output logic              ins_valid,
  output logic [7:0]        opcode,
  output logic [7:0]        operand1,
  output logic [7:0]        operand2,
  output logic [1:0]        ins_len,
  output logic [ADDR_W-1:0] ins_pc,
  output logic [ADDR_W-1:0] next_pc,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
`ifdef FETCH_STEP_EN
  input  logic              step,
`endif
  output logic              busy
);

  seq_state_t        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ins_start;
  logic [1:0]        byte_cnt;
  logic [1:0]        len_q;
  logic [1:0]        lut_len;
  logic [1:0]        cur_len;
  logic [7:0]        b0;
  logic [7:0]        b1;

  ins_len_lut u_len (
    .opcode (rom_data),
    .len    (lut_len)
  );

  // The length is only known once byte 0 arrives, so use the LUT directly on that beat.
  assign cur_len  = (byte_cnt == 2'd0) ? lut_len : len_q;
  assign rom_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ins_start <= RESET_PC;
      byte_cnt  <= 2'd0;
      len_q     <= 2'd1;
      b0        <= 8'h00;
      b1        <= 8'h00;
      rom_req   <= 1'b0;
      ins_valid <= 1'b0;
      opcode    <= 8'h00;
      operand1  <= 8'h00;
      operand2  <= 8'h00;
      ins_len   <= 2'd1;
      ins_pc    <= RESET_PC;
      next_pc   <= RESET_PC;
      busy      <= 1'b0;
    end else begin
      ins_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b1;
`ifdef FETCH_STEP_EN
          state <= STEP_WAIT;
`else
          state   <= FETCH;
          rom_req <= 1'b1;
`endif
        end
`ifdef FETCH_STEP_EN
        STEP_WAIT: begin
          if (step) begin
            state   <= FETCH;
            rom_req <= 1'b1;
          end
        end
`endif
        FETCH: begin
          if (rom_ack) begin
            pc       <= pc + ADDR_W'(1);
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd0) begin
              b0        <= rom_data;
              len_q     <= lut_len;
              ins_start <= pc;
            end
            if (byte_cnt == 2'd1) b1 <= rom_data;
            if (byte_cnt + 2'd1 == cur_len) begin
              state     <= ISSUE;
              rom_req   <= 1'b0;
              ins_valid <= 1'b1;
              opcode    <= (byte_cnt == 2'd0) ? rom_data : b0;
              operand1  <= (byte_cnt == 2'd1) ? rom_data :
                           (byte_cnt == 2'd2) ? b1 : 8'h00;
              operand2  <= (byte_cnt == 2'd2) ? rom_data : 8'h00;
              ins_len   <= cur_len;
              ins_pc    <= (byte_cnt == 2'd0) ? pc : ins_start;
              next_pc   <= pc + ADDR_W'(1);
            end
          end
        end
        ISSUE: state <= WAIT_EXEC;
        WAIT_EXEC: begin
          if (exec_done) begin
            if (pc_load) pc <= pc_load_val;
            byte_cnt <= 2'd0;
`ifdef FETCH_STEP_EN
            state <= STEP_WAIT;
`else
            state   <= FETCH;
            rom_req <= 1'b1;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          rom_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: zero-wait and wait-state ROM, jumps, PC wrap, mid-fetch reset.
// A second instance with RESET_PC=FFFF covers address wrap; FETCH_STEP_EN adds the single-step case.
module tb_fetch_sequencer;
  import mcu51_pkg::*;

`ifdef FETCH_STEP_EN
  localparam int SL = 1;
`else
  localparam int SL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        rom_req, rom_ack, ins_valid, busy;
  logic [15:0] rom_addr, ins_pc, next_pc;
  logic [7:0]  rom_data, opcode, operand1, operand2;
  logic [1:0]  ins_len;
  logic        exec_done, pc_load;
  logic [15:0] pc_load_val;
  logic        step;

  logic        rom2_req, ins_valid2, busy2;
  logic [15:0] rom2_addr, ins_pc2, next_pc2;
  logic [7:0]  rom2_data, opcode2, op1_2, op2_2;
  logic [1:0]  len2;

  logic [7:0]  mem [0:65535];
  int          wait_n = 0;
  int          wcnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          iv_count = 0;
  int          iv_snap;
  logic [7:0]  exp_op [3];

  always #5 clk = ~clk;

  assign rom_ack   = rom_req && (wcnt == wait_n);
  assign rom_data  = mem[rom_addr];
  assign rom2_data = mem[rom2_addr];

  always @(posedge clk) begin
    wcnt <= (rom_req && !rom_ack) ? wcnt + 1 : 0;
    if (ins_valid) iv_count <= iv_count + 1;
  end

  fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ack(rom_ack), .ins_valid(ins_valid),
    .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .ins_len(ins_len), .ins_pc(ins_pc), .next_pc(next_pc),
    .exec_done(exec_done), .pc_load(pc_load), .pc_load_val(pc_load_val),
`ifdef FETCH_STEP_EN
    .step(step),
`endif
    .busy(busy)
  );

  fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst2_n), .rom_req(rom2_req), .rom_addr(rom2_addr),
    .rom_data(rom2_data), .rom_ack(rom2_req), .ins_valid(ins_valid2),
    .opcode(opcode2), .operand1(op1_2), .operand2(op2_2),
    .ins_len(len2), .ins_pc(ins_pc2), .next_pc(next_pc2),
    .exec_done(1'b0), .pc_load(1'b0), .pc_load_val(16'h0000),
`ifdef FETCH_STEP_EN
    .step(1'b1),
`endif
    .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps negedges until ins_valid; the count of edges waited is the latency.
  task automatic wait_iv(input string tag, input int exp_n);
    int n;
    n = 0;
    while (ins_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n = 1'b0; rst2_n = 1'b0;
    exec_done = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0000;
    step = 1'b1;
    exp_op[0] = OP_NOP; exp_op[1] = OP_INC_A; exp_op[2] = OP_DEC_A;
    mem[0] = OP_NOP; mem[1] = OP_INC_A; mem[2] = OP_DEC_A; mem[3] = OP_NOP;
    @(negedge clk);
    @(negedge clk);

    chk("rst_rom_req", rom_req, 0);
    chk("rst_rom_addr", rom_addr, 16'h0000);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_operand1", operand1, 0);
    chk("rst_operand2", operand2, 0);
    chk("rst_ins_len", ins_len, 1);
    chk("rst_ins_pc", ins_pc, 16'h0000);
    chk("rst_next_pc", next_pc, 16'h0000);
    chk("rst_busy", busy, 0);

    // Zero-wait ROM, three 1-byte instructions, exec_done held for minimum period
    rst_n = 1'b1;
    exec_done = 1'b1;
    @(negedge clk);
    repeat (SL) @(negedge clk);
    chk("t1_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      chk("t1_fetch_req", rom_req, 1);
      chk("t1_fetch_addr", rom_addr, k);
      @(negedge clk);
      chk("t1_valid_lat", ins_valid, 1);
      chk("t1_ins_pc", ins_pc, k);
      chk("t1_ins_len", ins_len, 1);
      chk("t1_opcode", opcode, exp_op[k]);
      chk("t1_next_pc", next_pc, k + 1);
      @(negedge clk);
      chk("t1_valid_pulse", ins_valid, 0);
      @(negedge clk);
      repeat (SL) @(negedge clk);
    end
    exec_done = 1'b0;

    // 2-byte MOV A,#5A with two ROM wait cycles per byte
    wait_n = 2;
    mem[0] = OP_MOV_A_IMM; mem[1] = 8'h5A; mem[2] = OP_NOP;
    do_reset();
    wait_iv("t2_latency", 7 + SL);
    chk("t2_opcode", opcode, 8'h74);
    chk("t2_operand1", operand1, 8'h5A);
    chk("t2_operand2", operand2, 8'h00);
    chk("t2_ins_len", ins_len, 2);
    chk("t2_next_pc", next_pc, 16'h0002);
    chk("t2_ins_pc", ins_pc, 16'h0000);

    // LJMP 1234 followed by a taken jump
    wait_n = 0;
    mem[0] = OP_LJMP; mem[1] = 8'h12; mem[2] = 8'h34;
    mem[16'h1234] = OP_MOV_A_IMM; mem[16'h1235] = 8'hAB;
    do_reset();
    wait_iv("t3_latency", 4 + SL);
    chk("t3_opcode", opcode, 8'h02);
    chk("t3_operand1", operand1, 8'h12);
    chk("t3_operand2", operand2, 8'h34);
    chk("t3_ins_len", ins_len, 3);
    chk("t3_next_pc", next_pc, 16'h0003);
    exec_done = 1'b1; pc_load = 1'b1; pc_load_val = 16'h1234;
    @(negedge clk);
    chk("t3_wait_req", rom_req, 0);
    chk("t3_wait_addr", rom_addr, 16'h0003);
    @(negedge clk);
    repeat (SL) @(negedge clk);
    chk("t3_jump_req", rom_req, 1);
    chk("t3_jump_addr", rom_addr, 16'h1234);
    exec_done = 1'b0; pc_load = 1'b0;
    wait_iv("t3_latency2", 2);
    chk("t3_ins_pc2", ins_pc, 16'h1234);
    chk("t3_operand1b", operand1, 8'hAB);
    chk("t3_operand2_cleared", operand2, 8'h00);
    chk("t3_next_pc2", next_pc, 16'h1236);

    // pc_load without exec_done must be ignored
    pc_load = 1'b1; pc_load_val = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    chk("t3_noload_req", rom_req, 0);
    chk("t3_noload_addr", rom_addr, 16'h1236);
    pc_load = 1'b0; exec_done = 1'b1;
    @(negedge clk);
    repeat (SL) @(negedge clk);
    chk("t3_seq_req", rom_req, 1);
    chk("t3_seq_addr", rom_addr, 16'h1236);
    exec_done = 1'b0;

    // RESET_PC = FFFF: SJMP split across the address wrap
    mem[16'hFFFF] = OP_SJMP; mem[0] = 8'hFE;
    chk("t4_rst_addr", rom2_addr, 16'hFFFF);
    chk("t4_rst_next_pc", next_pc2, 16'hFFFF);
    rst2_n = 1'b1;
    @(negedge clk);
    repeat (SL) @(negedge clk);
    chk("t4_req", rom2_req, 1);
    chk("t4_addr0", rom2_addr, 16'hFFFF);
    @(negedge clk);
    chk("t4_addr1", rom2_addr, 16'h0000);
    @(negedge clk);
    chk("t4_valid", ins_valid2, 1);
    chk("t4_ins_pc", ins_pc2, 16'hFFFF);
    chk("t4_opcode", opcode2, 8'h80);
    chk("t4_operand1", op1_2, 8'hFE);
    chk("t4_ins_len", len2, 2);
    chk("t4_next_pc", next_pc2, 16'h0001);

    // Reset while byte 1 of MOV DPTR is pending
    wait_n = 2;
    mem[0] = OP_MOV_DPTR_IMM; mem[1] = 8'h11; mem[2] = 8'h22;
    do_reset();
    repeat (4 + SL) @(negedge clk);
    chk("t5_pending_req", rom_req, 1);
    chk("t5_pending_addr", rom_addr, 16'h0001);
    iv_snap = iv_count;
    rst_n = 1'b0;
    #1;
    chk("t5_req_drop", rom_req, 0);
    wait_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_no_issue_in_reset", iv_count, iv_snap);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (SL) @(negedge clk);
    chk("t5_restart_req", rom_req, 1);
    chk("t5_restart_addr", rom_addr, 16'h0000);
    wait_iv("t5_restart_lat", 3);
    chk("t5_aborted_not_issued", iv_count, iv_snap);
    chk("t5_ins_pc", ins_pc, 16'h0000);
    chk("t5_operand1", operand1, 8'h11);
    chk("t5_operand2", operand2, 8'h22);
    @(negedge clk);
    chk("t5_one_issue", iv_count, iv_snap + 1);

`ifdef FETCH_STEP_EN
    // Single-step gate
    step = 1'b0;
    mem[0] = OP_NOP;
    do_reset();
    repeat (5) @(negedge clk);
    chk("t6_hold_req", rom_req, 0);
    chk("t6_hold_busy", busy, 1);
    iv_snap = iv_count;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("t6_step_req", rom_req, 1);
    exec_done = 1'b1;
    @(negedge clk);
    chk("t6_valid", ins_valid, 1);
    repeat (5) @(negedge clk);
    chk("t6_after_req", rom_req, 0);
    chk("t6_one_issue", iv_count, iv_snap + 1);
    exec_done = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch/issue controller for the 8051 core. It reads opcode and operand bytes from program memory over a request/acknowledge port, tracks the program counter and the instruction length, and presents one complete instruction to the decoder/execute stage. It then waits for that stage to report completion before fetching again. It sits between the code ROM and the instruction decoder and is the only block that advances the PC.

## Interface
Parameters:
- `ADDR_W`, 16, program-counter and ROM address width
- `RESET_PC`, 16'h0000, PC value after reset

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rom_req`  out  1  ROM read request, held until acknowledged
- `rom_addr`  out  ADDR_W  byte address, equal to current PC while `rom_req`=1
- `rom_data`  in  8  ROM read data, valid in the cycle `rom_ack`=1
- `rom_ack`  in  1  ROM acknowledge; may be asserted in the same cycle as `rom_req`
- `ins_valid`  out  1  one-cycle pulse: `opcode`/`operand1`/`operand2`/`ins_len`/`ins_pc`/`next_pc` are valid
- `opcode`  out  8  instruction byte 0
- `operand1`  out  8  byte 1 (8'h00 if absent)
- `operand2`  out  8  byte 2 (8'h00 if absent)
- `ins_len`  out  2  instruction length: 1, 2 or 3
- `ins_pc`  out  ADDR_W  address of the opcode
- `next_pc`  out  ADDR_W  address following the last byte
- `exec_done`  in  1  execute stage has finished the issued instruction
- `pc_load`  in  1  qualified by `exec_done`: take `pc_load_val` as the new PC (jumps)
- `pc_load_val`  in  ADDR_W  jump target
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_EXEC (plus STEP_WAIT under the configuration macro).
- IDLE: entered on reset; exits to FETCH unconditionally on the first clock edge after `rst_n` deasserts.
- FETCH: `rom_req`=1, `rom_addr`=PC. At each edge with `rom_ack`=1:
  - the byte is stored at index `byte_cnt`;
  - PC increments by 1, wrapping from all-ones to 0;
  - `byte_cnt` increments.
- At byte 0, the length is latched from the length LUT applied to `rom_data`. When `byte_cnt` reaches the length, the state goes to ISSUE. Otherwise `rom_req` stays high for the next byte, with no idle cycle.
- ISSUE: `ins_valid`=1 for exactly one cycle, then WAIT_EXEC. `next_pc` equals the current PC.
- WAIT_EXEC: `exec_done` is sampled from the cycle after `ins_valid`. On `exec_done`:
  - if `pc_load`=1, PC is set to `pc_load_val`; else PC is unchanged;
  - the state goes to FETCH and `byte_cnt` clears.
- `exec_done` is ignored outside WAIT_EXEC. `pc_load` without `exec_done` is ignored.
- Length LUT follows the standard 8051 opcode map. Examples:
  - 00 NOP = 1; 04 INC A = 1; 14 DEC A = 1;
  - 74 MOV A,#d = 2; 80 SJMP = 2; aaa00001 AJMP = 2;
  - 02 LJMP = 3; 90 MOV DPTR,#d16 = 3;
  - A5 (reserved) = 1.
- Operand registers not filled by the current instruction read 8'h00.

## Timing
- Reset values:
  - `rom_req`=0, `rom_addr`=RESET_PC, `ins_valid`=0;
  - `opcode`/`operand1`/`operand2`=0, `ins_len`=1;
  - `ins_pc`=`next_pc`=RESET_PC, `busy`=0, PC=RESET_PC.
- Reset mid-operation: all state is cleared asynchronously and `rom_req` drops immediately. Any partially fetched instruction is discarded and never issued.
- Latency with zero-wait ROM (`rom_ack` tied to `rom_req`): an N-byte instruction takes N FETCH cycles, then `ins_valid` in cycle N+1. Each ROM wait cycle adds one cycle.
- Minimum per-instruction period: N + 1 + 1 cycles, with `exec_done` in the first WAIT_EXEC cycle.
- `rom_addr` changes only on an acknowledged edge or a PC load.

## Configuration
- `FETCH_STEP_EN` defined:
  - adds input `step` (1 bit) and state STEP_WAIT;
  - after reset and after every `exec_done`, the sequencer enters STEP_WAIT with `busy`=1 and `rom_req`=0;
  - it proceeds to FETCH on the edge where `step`=1; `step` held high gives free-running operation.
- `FETCH_STEP_EN` undefined: no `step` port and no STEP_WAIT; transitions go directly to FETCH.

## Structure
- Shared package `mcu51_pkg`: state encoding, `RESET_PC` default, opcode constants (NOP, INC_A, DEC_A, LJMP, AJMP, SJMP, MOV_A_IMM, MOV_DPTR_IMM), and the length function.
- One sub-module, `ins_len_lut`: combinational 8-bit opcode to 2-bit length, instantiated once on `rom_data`.

## Test plan
- Zero-wait ROM {00, 04, 14}:
  - three `ins_valid` pulses with `ins_pc` 0, 1, 2;
  - each has `ins_len`=1;
  - each `ins_valid` occurs 2 cycles after its fetch starts.
- ROM {74, 5A} with 2 wait cycles per byte:
  - one `ins_valid` with `opcode`=74, `operand1`=5A, `operand2`=00;
  - `ins_len`=2, `next_pc`=2.
- ROM at 0 = {02, 12, 34}; `exec_done` with `pc_load`=1 and `pc_load_val`=16'h1234:
  - next `rom_addr`=1234;
  - next `ins_pc`=1234.
- RESET_PC=16'hFFFF, 2-byte instruction:
  - bytes are read from FFFF then 0000;
  - `next_pc`=0001.
- Assert `rst_n`=0 while the second byte of 90 is pending:
  - `rom_req` is 0 in the same cycle;
  - after release, fetch restarts at RESET_PC;
  - no `ins_valid` occurs for the aborted instruction.
- With `FETCH_STEP_EN` defined and `step` held 0:
  - `rom_req` stays 0;
  - a single-cycle `step` pulse yields exactly one fetch and one `ins_valid`.
